// File: rtl/tmr_voter_if.sv
// Bundle of the replica inputs and the voted/status outputs of tmr_voter_reg.
// The master drives the replicas; the slave (the voter) returns vote, mismatch and fault status.
interface tmr_voter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             clr_fault;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             mismatch;
  logic [CNT_W-1:0] err_a;
  logic [CNT_W-1:0] err_b;
  logic [CNT_W-1:0] err_c;
  logic             fault_a;
  logic             fault_b;
  logic             fault_c;

  modport master (
    output in_valid, a, b, c, clr_fault,
    input  out_valid, out, mismatch, err_a, err_b, err_c, fault_a, fault_b, fault_c
  );

  modport slave (
    input  in_valid, a, b, c, clr_fault,
    output out_valid, out, mismatch, err_a, err_b, err_c, fault_a, fault_b, fault_c
  );
endinterface

// File: rtl/tmr_voter_reg.sv
// Registered 2-of-3 bitwise voter with per-channel health FSMs and saturating error counters.
// Optional TMR_EXCLUDE_EN: with exactly one channel faulted, vote only on the two remaining channels.
module tmr_voter_reg #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tmr_voter_if.slave   bus
);
  typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTED} state_t;

  localparam logic [7:0] THRESH = 8'(FAULT_THRESH);

  logic [2:0][WIDTH-1:0] rep;
  logic [WIDTH-1:0]      vote;
  logic                  vote_ok;
  logic                  excl;
  logic [2:0]            disagree;
  logic [2:0]            fault_vec;
  logic [2:0][CNT_W-1:0] err_vec;
  logic                  mismatch_next;
  logic [WIDTH-1:0]      out_reg;
  logic                  out_valid_reg;
  logic                  mismatch_reg;
`ifdef TMR_EXCLUDE_EN
  logic [WIDTH-1:0]      pair0;
  logic [WIDTH-1:0]      pair1;
`endif

  assign rep = {bus.c, bus.b, bus.a};

  always_comb begin
    vote    = (bus.a & bus.b) | (bus.b & bus.c) | (bus.a & bus.c);
    vote_ok = 1'b1;
    excl    = 1'b0;
`ifdef TMR_EXCLUDE_EN
    pair0   = rep[1];
    pair1   = rep[2];
    if ($countones(fault_vec) == 1) begin
      excl = 1'b1;
      case (fault_vec)
        3'b001:  begin pair0 = rep[1]; pair1 = rep[2]; end
        3'b010:  begin pair0 = rep[0]; pair1 = rep[2]; end
        default: begin pair0 = rep[0]; pair1 = rep[1]; end
      endcase
      // Disagreeing survivors give no trustworthy value: hold out, count nobody.
      if (pair0 == pair1) vote = pair0;
      else                vote_ok = 1'b0;
    end
`endif
    for (int i = 0; i < 3; i++) begin
      disagree[i] = bus.in_valid & vote_ok & (rep[i] != vote);
    end
    mismatch_next = excl ? (bus.in_valid & ~vote_ok) : |disagree;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      mismatch_reg  <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      mismatch_reg  <= mismatch_next;
      if (bus.in_valid && vote_ok) out_reg <= vote;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      state_t           state_reg, state_next, st;
      logic [7:0]       consec_reg, consec_next, cn;
      logic [CNT_W-1:0] err_reg, err_next, er;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg  <= HEALTHY;
          consec_reg <= '0;
          err_reg    <= '0;
        end else begin
          state_reg  <= state_next;
          consec_reg <= consec_next;
          err_reg    <= err_next;
        end
      end

      // Clear takes effect first, then the current sample is applied on top of it.
      always_comb begin
        st          = bus.clr_fault ? HEALTHY : state_reg;
        cn          = bus.clr_fault ? 8'd0 : consec_reg;
        er          = bus.clr_fault ? '0 : err_reg;
        state_next  = st;
        consec_next = cn;
        err_next    = er;
        if (disagree[gi]) begin
          if (er != '1) err_next = er + 1'b1;
          case (st)
            HEALTHY: begin
              consec_next = 8'd1;
              state_next  = (THRESH <= 8'd1) ? FAULTED : SUSPECT;
            end
            SUSPECT: begin
              consec_next = cn + 8'd1;
              if (cn + 8'd1 >= THRESH) state_next = FAULTED;
            end
            default: ;
          endcase
        end else if (bus.in_valid && vote_ok && st == SUSPECT) begin
          state_next  = HEALTHY;
          consec_next = 8'd0;
        end
      end

      assign fault_vec[gi] = (state_reg == FAULTED);
      assign err_vec[gi]   = err_reg;
    end
  endgenerate

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.mismatch  = mismatch_reg;
  assign bus.err_a     = err_vec[0];
  assign bus.err_b     = err_vec[1];
  assign bus.err_c     = err_vec[2];
  assign bus.fault_a   = fault_vec[0];
  assign bus.fault_b   = fault_vec[1];
  assign bus.fault_c   = fault_vec[2];
endmodule

// File: tb/tb_tmr_voter_reg.sv
// Scoreboard bench: two voter configurations (8/8/4 and 1/2/1) driven each cycle against a
// bit-counting majority model; a monitor pops expectations one edge later and compares.
module tb_tmr_voter_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmr_voter_if #(.WIDTH(8), .CNT_W(8)) if0 ();
  tmr_voter_if #(.WIDTH(1), .CNT_W(2)) if1 ();

  tmr_voter_reg #(.WIDTH(8), .CNT_W(8), .FAULT_THRESH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  tmr_voter_reg #(.WIDTH(1), .CNT_W(2), .FAULT_THRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    logic       ov;
    logic [7:0] o;
    logic       mm;
    int         e0, e1, e2;
    logic [2:0] f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;

  // staged stimulus, applied at the next falling edge
  logic       rst_s = 1'b0;
  logic       v_s[2];
  logic [7:0] a_s[2], b_s[2], c_s[2];
  logic       clr_s[2];

  // reference model state
  int         m_consec[2][3];
  bit         m_flt[2][3];
  int         m_err[2][3];
  logic [7:0] m_out[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic clr);
    v_s[d] = v; a_s[d] = a; b_s[d] = b; c_s[d] = c; clr_s[d] = clr;
  endtask

  task automatic model(input int d, output exp_t e);
    int w, th, emax, ones;
    logic [7:0] msk, vote;
    logic [7:0] x[3];
    bit mm;
    w = (d == 0) ? 8 : 1;
    th = (d == 0) ? 4 : 1;
    emax = (d == 0) ? 255 : 3;
    msk = (d == 0) ? 8'hFF : 8'h01;
    x[0] = a_s[d] & msk; x[1] = b_s[d] & msk; x[2] = c_s[d] & msk;
    mm = 1'b0;
    if (!rst_s) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_consec[d][ch] = 0; m_flt[d][ch] = 0; m_err[d][ch] = 0;
      end
      m_out[d] = 8'h00;
      e.ov = 1'b0;
    end else begin
      vote = 8'h00;
      for (int bi = 0; bi < w; bi++) begin
        ones = int'(x[0][bi]) + int'(x[1][bi]) + int'(x[2][bi]);
        vote[bi] = (ones >= 2);
      end
      if (clr_s[d]) begin
        for (int ch = 0; ch < 3; ch++) begin
          m_consec[d][ch] = 0; m_flt[d][ch] = 0; m_err[d][ch] = 0;
        end
      end
      if (v_s[d]) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (x[ch] != vote) begin
            mm = 1'b1;
            if (m_err[d][ch] < emax) m_err[d][ch]++;
            if (!m_flt[d][ch]) begin
              m_consec[d][ch]++;
              if (m_consec[d][ch] >= th) m_flt[d][ch] = 1;
            end
          end else if (!m_flt[d][ch]) begin
            m_consec[d][ch] = 0;
          end
        end
        m_out[d] = vote;
      end
      e.ov = v_s[d];
    end
    e.o = m_out[d];
    e.mm = mm;
    e.e0 = m_err[d][0]; e.e1 = m_err[d][1]; e.e2 = m_err[d][2];
    e.f = {m_flt[d][2], m_flt[d][1], m_flt[d][0]};
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    rst_n = rst_s;
    if0.in_valid = v_s[0]; if0.a = a_s[0]; if0.b = b_s[0]; if0.c = c_s[0];
    if0.clr_fault = clr_s[0];
    if1.in_valid = v_s[1]; if1.a = a_s[1][0]; if1.b = b_s[1][0]; if1.c = c_s[1][0];
    if1.clr_fault = clr_s[1];
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
  endtask

  // monitor: one expectation per DUT per edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("d0.out_valid", int'(if0.out_valid), int'(x.ov));
      chk("d0.out", int'(if0.out), int'(x.o));
      chk("d0.mismatch", int'(if0.mismatch), int'(x.mm));
      chk("d0.err_a", int'(if0.err_a), x.e0);
      chk("d0.err_b", int'(if0.err_b), x.e1);
      chk("d0.err_c", int'(if0.err_c), x.e2);
      chk("d0.fault", int'({if0.fault_c, if0.fault_b, if0.fault_a}), int'(x.f));
      $display("d0 t=%0t ov=%0b out=%02h mm=%0b err=%0d/%0d/%0d fault=%03b", $time,
               if0.out_valid, if0.out, if0.mismatch, if0.err_a, if0.err_b, if0.err_c,
               {if0.fault_c, if0.fault_b, if0.fault_a});
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("d1.out_valid", int'(if1.out_valid), int'(x.ov));
      chk("d1.out", int'(if1.out), int'(x.o[0]));
      chk("d1.mismatch", int'(if1.mismatch), int'(x.mm));
      chk("d1.err_a", int'(if1.err_a), x.e0);
      chk("d1.err_b", int'(if1.err_b), x.e1);
      chk("d1.err_c", int'(if1.err_c), x.e2);
      chk("d1.fault", int'({if1.fault_c, if1.fault_b, if1.fault_a}), int'(x.f));
      $display("d1 t=%0t ov=%0b out=%0b mm=%0b err=%0d/%0d/%0d fault=%03b", $time,
               if1.out_valid, if1.out, if1.mismatch, if1.err_a, if1.err_b, if1.err_c,
               {if1.fault_c, if1.fault_b, if1.fault_a});
    end
  end

  function automatic logic [7:0] corrupt(input logic [7:0] base);
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return base;
  endfunction

  initial begin
    logic [7:0] base;
    logic [2:0] combo;
    if0.in_valid = 0; if0.a = 0; if0.b = 0; if0.c = 0; if0.clr_fault = 0;
    if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.c = 0; if1.clr_fault = 0;
    set(0, 0, 0, 0, 0, 0); set(1, 0, 0, 0, 0, 0);
    rst_s = 1'b0;
    cyc(); cyc();
    rst_s = 1'b1;
    // dut0: 4 cycles of C disagreeing then C matching; dut1: 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      set(0, 1, 8'hA5, 8'hA5, (i < 4) ? 8'h5A : 8'hA5, 0);
      set(1, 1, {7'd0, combo[2]}, {7'd0, combo[1]}, {7'd0, combo[0]}, 0);
      cyc();
    end
    // dut1 channel A disagrees on 6 valid cycles separated by idle gaps (saturation)
    for (int i = 0; i < 12; i++) begin
      set(0, (i % 3) != 0, 8'hA5, 8'hA5, 8'hA5, 0);
      set(1, (i % 2) == 0, 8'h01, 8'h00, 8'h00, 0);
      cyc();
    end
    set(0, 0, 8'h00, 8'h00, 8'h00, 1); set(1, 0, 0, 0, 0, 1); cyc();
    set(0, 1, 8'h77, 8'h77, 8'h77, 0); set(1, 1, 1, 1, 1, 0); cyc();
    // clear coincident with a B disagreement
    set(0, 1, 8'h33, 8'h00, 8'h33, 1); set(1, 1, 1, 0, 1, 1); cyc();
    set(0, 0, 8'h00, 8'h00, 8'h00, 0); set(1, 0, 0, 0, 0, 0); cyc();
    // randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      rst_s = ($urandom_range(0, 99) != 0);
      for (int d = 0; d < 2; d++) begin
        base = 8'($urandom);
        set(d, $urandom_range(0, 3) != 0, corrupt(base), corrupt(base),
            ($urandom_range(0, 1) == 0) ? ~base : corrupt(base), $urandom_range(0, 29) == 0);
      end
      cyc();
    end
    rst_s = 1'b1;
    // mid-stream reset with a live disagreeing sample
    set(0, 1, 8'hF0, 8'h0F, 8'hF0, 0); set(1, 1, 1, 0, 0, 0); cyc();
    rst_s = 1'b0; cyc();
    rst_s = 1'b1;
    set(0, 0, 0, 0, 0, 0); set(1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/tmr_voter_reg.md
Name: tmr_voter_reg

Overview:
- Registered, parametrised triple-modular-redundancy voter.
- Takes three WIDTH-bit replicas of a signal and produces a bitwise 2-of-3 majority word one cycle later.
- Classifies each replica as healthy, suspect or faulted, and keeps per-channel saturating disagreement counts.
- Sits at the output of each triplicated register bank; the fault flags and counts feed the TMR status/scrub logic.

Parameters:
- WIDTH, 8, data width of each replica and of the voted output.
- CNT_W, 8, width of each per-channel saturating error counter.
- FAULT_THRESH, 4, consecutive valid disagreeing samples that move a channel to FAULTED (legal range 1..255).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  a/b/c carry a sample this cycle.
- a  in  WIDTH  replica A.
- b  in  WIDTH  replica B.
- c  in  WIDTH  replica C.
- clr_fault  in  1  one-cycle pulse; clears fault state and counters.
- out_valid  out  1  registered copy of in_valid.
- out  out  WIDTH  registered voted word.
- mismatch  out  1  registered; at least one replica differed from the voted word on a valid sample.
- err_a  out  CNT_W  saturating disagreement count, channel A.
- err_b  out  CNT_W  saturating disagreement count, channel B.
- err_c  out  CNT_W  saturating disagreement count, channel C.
- fault_a  out  1  channel A is in FAULTED.
- fault_b  out  1  channel B is in FAULTED.
- fault_c  out  1  channel C is in FAULTED.

Behaviour:
- Reset: sampled on the clk edge while rst_n=0. Afterwards out=0, out_valid=0, mismatch=0, err_*=0, fault_*=0, all channels HEALTHY, consecutive counters 0. Reset mid-stream discards the in-flight sample.
- Vote: v = (a&b)|(b&c)|(a&c), computed bitwise.
  - If in_valid=1: out<=v, out_valid<=1, mismatch<=(a!=v)|(b!=v)|(c!=v).
  - If in_valid=0: out holds, out_valid<=0, mismatch<=0.
  - Latency is exactly 1 cycle; throughput is 1 sample per cycle.
- Disagreement for channel X: in_valid & (X != v), compared as a whole word. More than one channel can disagree in the same cycle.
- Per-channel FSM and consecutive counter, updated only on in_valid cycles:
  - HEALTHY: on disagree go to SUSPECT with consec=1; on agree stay.
  - SUSPECT: on disagree, consec+1; when consec reaches FAULT_THRESH go to FAULTED. On agree go to HEALTHY with consec=0.
  - FAULTED: sticky. Left only through clr_fault or reset.
  - FAULT_THRESH=1: HEALTHY goes straight to FAULTED on the first disagreement.
- fault_X=1 exactly while channel X is in FAULTED. It is registered and asserts on the same edge that updates out for the triggering sample.
- err_X increments on every disagree cycle, including while FAULTED, and saturates at 2^CNT_W-1 with no wrap.
- clr_fault=1:
  - Every channel goes to HEALTHY; consec and err_* return to 0.
  - If the same cycle also carries a disagreeing valid sample, clear is applied first and the sample is then counted: that channel goes to SUSPECT with consec=1 and err=1 (with FAULT_THRESH=1 it goes to FAULTED).
  - out, out_valid and mismatch are unaffected.
- Word-level triple disagreement (a, b, c pairwise different): still vote bitwise. All three channels count a disagree, provided each differs from v.

Optional Feature:
- Macro: TMR_EXCLUDE_EN.
- Defined, exactly one channel FAULTED: the vote uses only the two healthy channels.
  - If they are equal, out<=that value and mismatch<=0.
  - If they differ, out holds its previous value and mismatch<=1.
  - The faulted channel still updates its err count against the two-channel result when they agree.
- Defined, two or three channels FAULTED: fall back to the normal 3-way bitwise vote.
- Not defined: always the 3-way vote, whatever the fault state.

Test Plan:
- Exhaustive single bit, WIDTH=1: 8 combinations of a/b/c with in_valid=1 -> out matches the majority truth table one cycle later; mismatch=0 only for 000 and 111.
- WIDTH=8: a=8'hA5, b=8'hA5, c=8'h5A for 3 valid cycles -> out=8'hA5, mismatch=1, err_c=3, fault_c=0. The 4th such cycle -> fault_c=1 on the same edge that out updates.
- After fault_c is set, drive c=b for 10 cycles -> fault_c stays 1, err_c stays 4. Pulse clr_fault -> fault_c=0, err_*=0.
- Saturation: CNT_W=2, channel A disagrees on 6 valid cycles -> err_a sequence 1,2,3,3,3,3. in_valid=0 gaps -> no count and out holds.
- Corner cases:
  - clr_fault coincident with a disagreeing sample on B -> err_b=1, fault_b=0.
  - rst_n=0 asserted mid-stream -> all outputs 0 on the next edge.
- With TMR_EXCLUDE_EN and C FAULTED: a=8'h11, b=8'h22 -> out holds its previous value, mismatch=1. Without the macro, same stimulus with c=8'h22 -> out=8'h22.
